// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: packet-level round-robin arbiter that shares one
// AXI-Stream datapath between up to four sources. A grant is held from
// the first beat to the tlast beat, so packets never interleave. Beats
// leave through a single output register tagged with their source index.
module axis_pkt_arbiter #(
    parameter int DATA_W    = 32,
    parameter int NUM_PORTS = 2
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [NUM_PORTS*DATA_W-1:0]   s_axis_tdata,
    input  logic [NUM_PORTS*DATA_W/8-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]          s_axis_tlast,
    input  logic [NUM_PORTS-1:0]          s_axis_tvalid,
    output logic [NUM_PORTS-1:0]          s_axis_tready,
    output logic [DATA_W-1:0]             m_axis_tdata,
    output logic [DATA_W/8-1:0]           m_axis_tkeep,
    output logic                          m_axis_tlast,
    output logic [1:0]                    m_axis_tdest,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          busy,
    output logic [15:0]                   pkt_count
);

    localparam int KEEP_W = DATA_W / 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0]        grant;
    logic [1:0]        last_grant;
    logic [1:0]        arb_pick;
    logic [1:0]        pick_hi;
    logic              found_hi;
    logic              arb_any;

    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic [KEEP_W-1:0] sel_keep;

    logic              out_space;
    logic              accept;

    // Round-robin pick: lowest requester above last_grant, else lowest requester overall
    always_comb begin
        arb_any  = 1'b0;
        arb_pick = 2'd0;
        pick_hi  = 2'd0;
        found_hi = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (s_axis_tvalid[i]) begin
                arb_any  = 1'b1;
                arb_pick = 2'(i);
                if (2'(i) > last_grant) begin
                    pick_hi  = 2'(i);
                    found_hi = 1'b1;
                end
            end
        end
        if (found_hi) begin
            arb_pick = pick_hi;
        end
    end

    // Route the granted source's beat towards the output register
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant == 2'(i)) begin
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
                sel_data  = s_axis_tdata[i*DATA_W +: DATA_W];
                sel_keep  = s_axis_tkeep[i*KEEP_W +: KEEP_W];
            end
        end
    end

    assign out_space = !m_axis_tvalid || m_axis_tready;
    assign accept    = (state == BUSY) && sel_valid && out_space;

    // Next-state, per-source ready and busy flag; only the granted port may see ready
    always_comb begin
        state_next    = state;
        s_axis_tready = '0;
        busy          = 1'b0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (grant == 2'(i)) begin
                        s_axis_tready[i] = out_space;
                    end
                end
                if (accept && sel_last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant is captured during the single arbitration cycle and held for the packet
    always_ff @(posedge aclk) begin
        if (areset) begin
            grant <= 2'd0;
        end else if (state == IDLE && arb_any) begin
            grant <= arb_pick;
        end
    end

    // Completed packet: remember its source for fairness and count it
    always_ff @(posedge aclk) begin
        if (areset) begin
            last_grant <= 2'(NUM_PORTS - 1);
            pkt_count  <= 16'd0;
        end else if (accept && sel_last) begin
            last_grant <= grant;
            pkt_count  <= pkt_count + 16'd1;
        end
    end

    // Output register: load on accept, drop valid once drained, hold while stalled
    always_ff @(posedge aclk) begin
        if (areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdest  <= 2'd0;
        end else if (accept) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= sel_data;
            m_axis_tkeep  <= sel_keep;
            m_axis_tlast  <= sel_last;
            m_axis_tdest  <= grant;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb_axis_pkt_arbiter: directed bench for the two-port packet arbiter.
// A vector table covers reset, first grant, fairness and single-beat
// packets; queue-driven sequences cover contention, backpressure,
// reset in the middle of a packet and counter wrap.
module tb_axis_pkt_arbiter;

    logic        aclk;
    logic        areset;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic [1:0]  s_axis_tlast;
    logic [1:0]  s_axis_tvalid;
    logic [1:0]  s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic [1:0]  m_axis_tdest;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        busy;
    logic [15:0] pkt_count;

    int compared = 0;
    int failed   = 0;

    axis_pkt_arbiter #(
        .DATA_W   (32),
        .NUM_PORTS(2)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tdest (m_axis_tdest),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .busy         (busy),
        .pkt_count    (pkt_count)
    );

    // Free-running 10-unit clock
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    typedef struct {
        logic        rst;
        logic [1:0]  vld;
        logic [1:0]  lst;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [3:0]  kp;
        logic        mrdy;
        logic        mv;
        logic [31:0] md;
        logic [3:0]  mk;
        logic        ml;
        logic [1:0]  dst;
        logic [1:0]  srdy;
        logic        bsy;
        logic [15:0] cnt;
    } VecT;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } BeatT;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [1:0]  dest;
    } ExpT;

    VecT  vecs[13];
    BeatT src0Q[$];
    BeatT src1Q[$];
    ExpT  expQ[$];

    function automatic VecT mkVec(logic rst, logic [1:0] vld, logic [1:0] lst,
                                  logic [31:0] d0, logic [31:0] d1, logic mrdy,
                                  logic mv, logic [31:0] md, logic ml, logic [1:0] dst,
                                  logic [1:0] srdy, logic bsy, logic [15:0] cnt);
        VecT v;
        v.rst = rst; v.vld = vld; v.lst = lst; v.d0 = d0; v.d1 = d1;
        v.kp = 4'hF; v.mrdy = mrdy; v.mv = mv; v.md = md; v.mk = 4'hF;
        v.ml = ml; v.dst = dst; v.srdy = srdy; v.bsy = bsy; v.cnt = cnt;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input VecT v);
        areset        = v.rst;
        s_axis_tvalid = v.vld;
        s_axis_tlast  = v.lst;
        s_axis_tdata  = {v.d1, v.d0};
        s_axis_tkeep  = {v.kp, v.kp};
        m_axis_tready = v.mrdy;
    endtask

    task automatic checkOutput(input VecT v, input int idx);
        checkVal($sformatf("vec%0d m_tvalid", idx), 32'(m_axis_tvalid), 32'(v.mv));
        checkVal($sformatf("vec%0d s_tready", idx), 32'(s_axis_tready), 32'(v.srdy));
        checkVal($sformatf("vec%0d busy", idx), 32'(busy), 32'(v.bsy));
        checkVal($sformatf("vec%0d pkt_count", idx), 32'(pkt_count), 32'(v.cnt));
        if (v.mv) begin
            checkVal($sformatf("vec%0d m_tdata", idx), m_axis_tdata, v.md);
            checkVal($sformatf("vec%0d m_tkeep", idx), 32'(m_axis_tkeep), 32'(v.mk));
            checkVal($sformatf("vec%0d m_tlast", idx), 32'(m_axis_tlast), 32'(v.ml));
            checkVal($sformatf("vec%0d m_tdest", idx), 32'(m_axis_tdest), 32'(v.dst));
        end
    endtask

    task automatic doReset();
        areset        = 1'b1;
        s_axis_tvalid = 2'b00;
        s_axis_tlast  = 2'b00;
        m_axis_tready = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    task automatic pushBeat(input int port, input logic [31:0] data, input logic [3:0] keep, input logic last);
        BeatT b;
        ExpT  e;
        b.data = data; b.keep = keep; b.last = last;
        e.data = data; e.keep = keep; e.last = last; e.dest = 2'(port);
        if (port == 0) src0Q.push_back(b);
        else src1Q.push_back(b);
        expQ.push_back(e);
    endtask

    // Drive queued beats as AXI-Stream sources, score output beats in order,
    // and check that a stalled output holds its data.
    task automatic driveTraffic(input string tag, input logic [3:0] rdyPat,
                                input int maxCycles, output int lastInCycle);
        int          cyc;
        logic        hs0, hs1, preV, preRdy;
        logic [31:0] preD;
        ExpT         e;
        BeatT        dropped;
        cyc         = 0;
        lastInCycle = -1;
        while ((src0Q.size() > 0 || src1Q.size() > 0 || expQ.size() > 0) && cyc < maxCycles) begin
            s_axis_tvalid[0] = (src0Q.size() > 0);
            if (src0Q.size() > 0) begin
                s_axis_tdata[31:0] = src0Q[0].data;
                s_axis_tkeep[3:0]  = src0Q[0].keep;
                s_axis_tlast[0]    = src0Q[0].last;
            end
            s_axis_tvalid[1] = (src1Q.size() > 0);
            if (src1Q.size() > 0) begin
                s_axis_tdata[63:32] = src1Q[0].data;
                s_axis_tkeep[7:4]   = src1Q[0].keep;
                s_axis_tlast[1]     = src1Q[0].last;
            end
            m_axis_tready = rdyPat[cyc % 4];
            #3;
            hs0    = s_axis_tvalid[0] && s_axis_tready[0];
            hs1    = s_axis_tvalid[1] && s_axis_tready[1];
            preV   = m_axis_tvalid;
            preRdy = m_axis_tready;
            preD   = m_axis_tdata;
            if (preV && preRdy) begin
                if (expQ.size() == 0) begin
                    compared++;
                    failed++;
                    $display("[TB] FAIL %s extra beat: got data 0x%0h, required no beat", tag, m_axis_tdata);
                end else begin
                    e = expQ.pop_front();
                    checkVal({tag, " tdata"}, m_axis_tdata, e.data);
                    checkVal({tag, " tkeep"}, 32'(m_axis_tkeep), 32'(e.keep));
                    checkVal({tag, " tlast"}, 32'(m_axis_tlast), 32'(e.last));
                    checkVal({tag, " tdest"}, 32'(m_axis_tdest), 32'(e.dest));
                end
            end
            @(posedge aclk);
            #1;
            if (preV && !preRdy) begin
                checkVal({tag, " stall tvalid"}, 32'(m_axis_tvalid), 32'd1);
                checkVal({tag, " stall tdata"}, m_axis_tdata, preD);
            end
            if (hs0) begin
                dropped     = src0Q.pop_front();
                lastInCycle = cyc + 1;
            end
            if (hs1) begin
                dropped     = src1Q.pop_front();
                lastInCycle = cyc + 1;
            end
            cyc++;
        end
        s_axis_tvalid = 2'b00;
        s_axis_tlast  = 2'b00;
        m_axis_tready = 1'b1;
        if (src0Q.size() > 0 || src1Q.size() > 0 || expQ.size() > 0) begin
            compared++;
            failed++;
            $display("[TB] FAIL %s timeout: %0d beats still outstanding, required 0", tag, expQ.size());
            src0Q.delete();
            src1Q.delete();
            expQ.delete();
        end
    endtask

    // Main test sequence
    initial begin
        int lastIn;

        //                 rst vld    lst    d0          d1          rdy  mv  md          ml  dst   srdy   bsy cnt
        vecs[0]  = mkVec(1, 2'b11, 2'b11, 32'hA0,     32'hB0,     1,   0,  32'h0,      0,  2'd0, 2'b00, 0,  16'd0);
        vecs[1]  = mkVec(1, 2'b11, 2'b11, 32'hA0,     32'hB0,     1,   0,  32'h0,      0,  2'd0, 2'b00, 0,  16'd0);
        vecs[2]  = mkVec(1, 2'b11, 2'b11, 32'hA0,     32'hB0,     1,   0,  32'h0,      0,  2'd0, 2'b00, 0,  16'd0);
        vecs[3]  = mkVec(0, 2'b11, 2'b11, 32'hA0,     32'hB0,     1,   0,  32'h0,      0,  2'd0, 2'b01, 1,  16'd0);
        vecs[4]  = mkVec(0, 2'b11, 2'b11, 32'hA0,     32'hB0,     1,   1,  32'hA0,     1,  2'd0, 2'b00, 0,  16'd1);
        vecs[5]  = mkVec(0, 2'b11, 2'b11, 32'hA0,     32'hB0,     1,   0,  32'h0,      0,  2'd0, 2'b10, 1,  16'd1);
        vecs[6]  = mkVec(0, 2'b11, 2'b11, 32'hA0,     32'hB0,     1,   1,  32'hB0,     1,  2'd1, 2'b00, 0,  16'd2);
        vecs[7]  = mkVec(0, 2'b00, 2'b00, 32'h0,      32'h0,      1,   0,  32'h0,      0,  2'd0, 2'b00, 0,  16'd2);
        vecs[8]  = mkVec(0, 2'b01, 2'b01, 32'h55,     32'h0,      1,   0,  32'h0,      0,  2'd0, 2'b01, 1,  16'd2);
        vecs[9]  = mkVec(0, 2'b01, 2'b01, 32'h55,     32'h0,      1,   1,  32'h55,     1,  2'd0, 2'b00, 0,  16'd3);
        vecs[10] = mkVec(0, 2'b01, 2'b01, 32'h56,     32'h0,      1,   0,  32'h0,      0,  2'd0, 2'b01, 1,  16'd3);
        vecs[11] = mkVec(0, 2'b01, 2'b01, 32'h56,     32'h0,      1,   1,  32'h56,     1,  2'd0, 2'b00, 0,  16'd4);
        vecs[12] = mkVec(0, 2'b00, 2'b00, 32'h0,      32'h0,      1,   0,  32'h0,      0,  2'd0, 2'b00, 0,  16'd4);

        applyStimulus(vecs[0]);
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            @(posedge aclk);
            #1;
            checkOutput(vecs[i], i);
        end

        // Contention: both ports stream two 4-beat packets each
        $display("[TB] contention");
        doReset();
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < 4; b++) pushBeat(0, 32'(p * 4 + b), 4'hF, b == 3);
            for (int b = 0; b < 4; b++) pushBeat(1, 32'h1000_0000 + 32'(p * 4 + b), 4'hF, b == 3);
        end
        driveTraffic("contention", 4'b1111, 60, lastIn);
        checkVal("contention input cycles", 32'(lastIn), 32'd20);
        checkVal("contention pkt_count", 32'(pkt_count), 32'd4);
        checkVal("contention busy", 32'(busy), 32'd0);

        // Backpressure: 3-beat packet on port 1 with ready pattern 1,0,0,1
        $display("[TB] backpressure");
        pushBeat(1, 32'hA, 4'hF, 1'b0);
        pushBeat(1, 32'hB, 4'hF, 1'b0);
        pushBeat(1, 32'hC, 4'h3, 1'b1);
        driveTraffic("backpressure", 4'b1001, 40, lastIn);
        checkVal("backpressure pkt_count", 32'(pkt_count), 32'd5);
        checkVal("backpressure busy", 32'(busy), 32'd0);

        // Reset after two beats of a 5-beat port-1 packet
        $display("[TB] reset mid-packet");
        s_axis_tvalid        = 2'b10;
        s_axis_tlast         = 2'b00;
        s_axis_tkeep         = 8'hFF;
        s_axis_tdata[63:32]  = 32'h1000_0000;
        m_axis_tready        = 1'b1;
        @(posedge aclk);
        #1;
        checkVal("midrst grant busy", 32'(busy), 32'd1);
        checkVal("midrst grant tready", 32'(s_axis_tready), 32'b10);
        checkVal("midrst grant tvalid", 32'(m_axis_tvalid), 32'd0);
        @(posedge aclk);
        #1;
        checkVal("midrst beat0 tvalid", 32'(m_axis_tvalid), 32'd1);
        checkVal("midrst beat0 tdata", m_axis_tdata, 32'h1000_0000);
        checkVal("midrst beat0 tlast", 32'(m_axis_tlast), 32'd0);
        checkVal("midrst beat0 tdest", 32'(m_axis_tdest), 32'd1);
        s_axis_tdata[63:32] = 32'h1000_0001;
        @(posedge aclk);
        #1;
        checkVal("midrst beat1 tvalid", 32'(m_axis_tvalid), 32'd1);
        checkVal("midrst beat1 tdata", m_axis_tdata, 32'h1000_0001);
        checkVal("midrst beat1 tlast", 32'(m_axis_tlast), 32'd0);
        s_axis_tdata[63:32] = 32'h1000_0002;
        areset              = 1'b1;
        @(posedge aclk);
        #1;
        checkVal("midrst after reset tvalid", 32'(m_axis_tvalid), 32'd0);
        checkVal("midrst after reset busy", 32'(busy), 32'd0);
        checkVal("midrst after reset tready", 32'(s_axis_tready), 32'd0);
        checkVal("midrst after reset pkt_count", 32'(pkt_count), 32'd0);
        areset        = 1'b0;
        s_axis_tvalid = 2'b00;
        for (int b = 0; b < 5; b++) pushBeat(1, 32'h1000_0000 + 32'(b), 4'hF, b == 4);
        driveTraffic("midrst resend", 4'b1111, 40, lastIn);
        checkVal("midrst resend pkt_count", 32'(pkt_count), 32'd1);

        // Counter wrap: preload near the top, then two single-beat packets
        $display("[TB] counter wrap");
        force dut.pkt_count = 16'hFFFE;
        #1;
        release dut.pkt_count;
        checkVal("wrap preload", 32'(pkt_count), 32'hFFFE);
        pushBeat(0, 32'h77, 4'hF, 1'b1);
        pushBeat(0, 32'h78, 4'hF, 1'b1);
        driveTraffic("wrap", 4'b1111, 40, lastIn);
        checkVal("wrap pkt_count", 32'(pkt_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
